// File: rtl/mux41_rr_arbiter_pkg.sv
// Shared types and constants for the 4-requester round-robin mux arbiter.
// State encoding, requester count, select width and a one-hot helper.
package mux41_rr_arbiter_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/mux41_rr_arbiter_rr_pick4.sv
// Combinational rotating priority pick: first set request after ptr,
// optionally skipping the current owner.
module rr_pick4
  import mux41_rr_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  input  logic               excl_en,
  input  logic [SEL_W-1:0]   excl,
  output logic               found,
  output logic [SEL_W-1:0]   idx
);

  logic [SEL_W-1:0] cand;

  // Offsets 1..4 so ptr itself is the lowest-priority candidate.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = ptr + SEL_W'(off);
      if (!found && req[cand] && !(excl_en && (cand == excl))) begin
        found = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mux41_rr_arbiter.sv
// Round-robin arbiter driving a shared 4:1 single-bit mux; grants are bounded
// to HOLD_MAX cycles under contention, y is gated by valid.
module mux41_rr_arbiter
  import mux41_rr_arbiter_pkg::*;
#(
  parameter int HOLD_MAX = 4,
  parameter int CNT_W    = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               a,
  input  logic               b,
  input  logic               c,
  input  logic               d,
  output logic [NUM_REQ-1:0] gnt,
  output logic               s1,
  output logic               s0,
  output logic               valid,
  output logic               y
);

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [SEL_W-1:0]   last_q, last_d;
  logic [CNT_W-1:0]   hold_q, hold_d;
  logic               valid_q, valid_d;

  logic               pick_found;
  logic [SEL_W-1:0]   pick_idx;
  logic               in_grant;
  logic               owner_req;

  assign in_grant  = (state_q == ST_GRANT);
  assign owner_req = req[last_q];

  // While granted, last_q is the owner, so excluding it yields "others pending".
  rr_pick4 u_pick (
    .req     (req),
    .ptr     (last_q),
    .excl_en (in_grant),
    .excl    (last_q),
    .found   (pick_found),
    .idx     (pick_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      sel_q   <= '0;
      last_q  <= SEL_W'(NUM_REQ - 1);
      hold_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      hold_q  <= hold_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    last_d  = last_q;
    hold_d  = hold_q;
    valid_d = valid_q;
    unique case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_d = ST_GRANT;
          gnt_d   = onehot(pick_idx);
          sel_d   = pick_idx;
          last_d  = pick_idx;
          hold_d  = '0;
          valid_d = 1'b1;
        end
      end
      ST_GRANT: begin
        if (!owner_req) begin
          if (pick_found) begin
            gnt_d  = onehot(pick_idx);
            sel_d  = pick_idx;
            last_d = pick_idx;
            hold_d = '0;
          end else begin
            // Selects keep their last value while idle.
            state_d = ST_IDLE;
            gnt_d   = '0;
            valid_d = 1'b0;
            hold_d  = '0;
          end
        end else if (!pick_found) begin
          hold_d = '0;
        end else if (hold_q == CNT_W'(HOLD_MAX - 1)) begin
          gnt_d  = onehot(pick_idx);
          sel_d  = pick_idx;
          last_d = pick_idx;
          hold_d = '0;
        end else begin
          hold_d = hold_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = '0;
        valid_d = 1'b0;
        hold_d  = '0;
      end
    endcase
  end

  always_comb begin
    gnt   = gnt_q;
    s1    = sel_q[1];
    s0    = sel_q[0];
    valid = valid_q;
    y     = 1'b0;
    if (valid_q) begin
      unique case (sel_q)
        2'd0:    y = a;
        2'd1:    y = b;
        2'd2:    y = c;
        default: y = d;
      endcase
    end
  end

endmodule

// File: tb/tb_mux41_rr_arbiter.sv
// Directed bench for mux41_rr_arbiter: a vector table plus hand-written
// sequences for hold-limit rotation, starvation-free holding and async reset.
module tb_mux41_rr_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       a, b, c, d;

  logic [3:0] gnt4, gnt1;
  logic       s1_4, s0_4, valid4, y4;
  logic       s1_1, s0_1, valid1, y1;

  mux41_rr_arbiter #(.HOLD_MAX(4), .CNT_W(3)) dut4 (
    .clk(clk), .rst_n(rst_n), .req(req), .a(a), .b(b), .c(c), .d(d),
    .gnt(gnt4), .s1(s1_4), .s0(s0_4), .valid(valid4), .y(y4)
  );

  mux41_rr_arbiter #(.HOLD_MAX(1), .CNT_W(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .req(req), .a(a), .b(b), .c(c), .d(d),
    .gnt(gnt1), .s1(s1_1), .s0(s0_1), .valid(valid1), .y(y1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wire [7:0] act4 = {gnt4, s1_4, s0_4, valid4, y4};
  wire [7:0] act1 = {gnt1, s1_1, s0_1, valid1, y1};

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [3:0] req;
    logic [3:0] dat;  // {d,c,b,a}
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       vld;
    logic       y;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: gnt,s1s0,valid,y got %b required %b", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] r, input logic [3:0] dat);
    req = r;
    {d, c, b, a} = dat;
  endtask

  function automatic logic [7:0] expv(input int owner, input logic vld, input logic yv,
                                      input int sel);
    logic [3:0] oh;
    logic [1:0] s;
    oh = vld ? (4'b0001 << owner) : 4'b0000;
    s  = sel[1:0];
    return {oh, s, vld, yv};
  endfunction

  initial begin
    // gnt              sel    vld   y
    tbl[0] = '{4'b0001, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b1};
    tbl[1] = '{4'b0001, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b1};
    tbl[2] = '{4'b0001, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b1};
    tbl[3] = '{4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0};
    tbl[4] = '{4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 1'b0};
    tbl[5] = '{4'b0010, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b1};
    tbl[6] = '{4'b1001, 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b1};
    tbl[7] = '{4'b0000, 4'b1000, 4'b0000, 2'd3, 1'b0, 1'b0};

    rst_n = 1'b0;
    drive(4'b0000, 4'b0000);
    step();
    step();
    check("reset", act4, 8'b0000_00_0_0);
    rst_n = 1'b1;

    // Single requester, data follow, release, owner drop with no bubble.
    for (int i = 0; i < 8; i++) begin
      drive(tbl[i].req, tbl[i].dat);
      step();
      check($sformatf("tbl%0d", i), act4,
            {tbl[i].gnt, tbl[i].sel, tbl[i].vld, tbl[i].y});
    end

    // Full contention: each owner holds 4 cycles, rotation wraps 3 -> 0.
    drive(4'b1111, 4'b0101);
    for (int e = 1; e <= 17; e++) begin
      int owner;
      logic [3:0] datv;
      datv  = 4'b0101;
      owner = ((e - 1) / 4) % 4;
      step();
      check($sformatf("contend_e%0d", e), act4, expv(owner, 1'b1, datv[owner], owner));
    end
    drive(4'b0000, 4'b0101);
    step();
    check("contend_release", act4, expv(0, 1'b0, 1'b0, 0));

    // Lone owner is never rotated away, then yields after HOLD_MAX under contention.
    drive(4'b0100, 4'b0100);
    for (int e = 1; e <= 10; e++) begin
      step();
      check($sformatf("lone_e%0d", e), act4, expv(2, 1'b1, 1'b1, 2));
    end
    drive(4'b0101, 4'b0100);
    for (int e = 1; e <= 3; e++) begin
      step();
      check($sformatf("yield_e%0d", e), act4, expv(2, 1'b1, 1'b1, 2));
    end
    step();
    check("yield_rotate", act4, expv(0, 1'b1, 1'b0, 0));
    drive(4'b0000, 4'b0100);
    step();
    check("yield_release", act4, expv(0, 1'b0, 1'b0, 0));

    // Asynchronous reset mid-grant, pointer returns to 3.
    drive(4'b0010, 4'b0010);
    step();
    check("pre_reset_grant", act4, expv(1, 1'b1, 1'b1, 1));
    #3 rst_n = 1'b0;
    #1 check("async_reset", act4, 8'b0000_00_0_0);
    #1 rst_n = 1'b1;
    drive(4'b1010, 4'b0010);
    step();
    check("post_reset_pick", act4, expv(1, 1'b1, 1'b1, 1));

    // HOLD_MAX=1 instance alternates every cycle under contention.
    drive(4'b0000, 4'b0000);
    step();
    #2 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    check("h1_reset", act1, 8'b0000_00_0_0);
    drive(4'b0101, 4'b0001);
    for (int e = 1; e <= 6; e++) begin
      int owner;
      owner = (e % 2 == 1) ? 0 : 2;
      step();
      check($sformatf("h1_e%0d", e), act1,
            expv(owner, 1'b1, (owner == 0) ? 1'b1 : 1'b0, owner));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mux41_rr_arbiter.md
Name: mux41_rr_arbiter

Overview:
Round-robin arbiter that shares one 4:1 single-bit mux path between four requesters. It drives the mux selects s1/s0 and one-hot grants, and bounds each grant to HOLD_MAX cycles when other requesters are waiting. The output bit y is the granted requester's data, gated by valid. It sits between the requesting lab blocks and the shared output line.

Parameters:
HOLD_MAX, 4, maximum consecutive cycles one requester keeps the grant while another request is pending; legal range 1..8
CNT_W, 3, hold counter width; must satisfy 2**CNT_W >= HOLD_MAX

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
req  input  4  request per requester; bit0=a, bit1=b, bit2=c, bit3=d
a  input  1  requester 0 data
b  input  1  requester 1 data
c  input  1  requester 2 data
d  input  1  requester 3 data
gnt  output  4  one-hot grant (registered), 0000 when idle
s1  output  1  mux select MSB (registered)
s0  output  1  mux select LSB (registered)
valid  output  1  high while any grant is active (registered)
y  output  1  selected data: sel 00->a, 01->b, 10->c, 11->d; forced 0 when valid=0 (combinational from registered selects)

Behaviour:
- Clock/reset: single clock clk; reset rst_n is asynchronous, active-low.
- Reset values: gnt=0000, {s1,s0}=00, valid=0, y=0, state=IDLE, hold_cnt=0, last=3 (so requester 0 has first priority after reset).
- Reset asserted mid-grant: all outputs drop to reset values immediately, without waiting for clk.
- FSM has two states: IDLE and GRANT.
- IDLE: when req!=0, pick the first set bit scanning last+1, last+2, ... (mod 4). At the next edge: gnt=onehot(k), {s1,s0}=k, valid=1, hold_cnt=0, last=k, state=GRANT. Latency from req to gnt is one cycle.
- GRANT, current owner k, evaluated each edge:
  - req[k]=0 and other requests pending: regrant to the next requester in rotation after k at this edge. There is no idle bubble.
  - req[k]=0 and no other request pending: go to IDLE; gnt=0000 and valid=0. {s1,s0} hold their last value.
  - req[k]=1, another request pending, and hold_cnt==HOLD_MAX-1: rotate to the next requester after k; hold_cnt=0.
  - req[k]=1, no other request pending: keep the grant; hold_cnt holds at 0, so the owner is never starved by an expired count.
  - Otherwise keep the grant and increment hold_cnt.
- HOLD_MAX=1: under contention the grant rotates every cycle.
- Every grant change updates last to the new owner and resets hold_cnt to 0.
- Wrap-around: the scan after requester 3 continues at requester 0.
- gnt is always one-hot or zero; valid == |gnt.
- Simultaneous events: a new request arriving in the same cycle the owner drops is eligible for that edge's pick. Requests only enter arbitration at a pick.

Decomposition:
- Shared package: state encoding (IDLE=0, GRANT=1), NUM_REQ=4, SEL_W=2.
- One combinational sub-module, rr_pick4:
  - inputs: req[3:0], ptr[1:0], excl_en, excl[1:0]
  - outputs: found, idx[1:0]
  - function: first set bit after ptr in rotation, optionally excluding the current owner.
- The top level holds the FSM, hold counter, registers, and output mux.

Test Plan:
1. Reset, then req=0001 for 3 cycles with a=1 -> gnt=0001 one cycle later, s1s0=00, valid=1, y=1; req=0000 -> next edge gnt=0000, valid=0, y=0.
2. req=1111 held, HOLD_MAX=4 -> grant sequence 0001(4 cycles), 0010(4), 0100(4), 1000(4), 0001 (wrap-around); s1s0 tracks 00,01,10,11.
3. Owner 1 (req=0010) drops req while req=1001 -> next edge gnt=1000, s1s0=11, with no cycle of valid=0.
4. req=0100 alone for 10 cycles -> gnt=0100 for all 10 cycles; raise req bit0 at cycle 10 -> grant moves to 0001 within HOLD_MAX cycles.
5. Grant active (gnt=0010), pulse rst_n low between clock edges -> gnt=0000, valid=0, y=0 immediately; after release, req=1010 -> gnt=0010 (pointer reset to 3, so bit1 is the first set bit from 0).
6. HOLD_MAX=1, req=0101 held -> gnt alternates 0001,0100 every cycle; y alternates a,c.
